// File: rtl/demux_route_if.sv
// Upstream stream plus the two downstream sink channels of the block-routing demux.
interface demux_route_if #(
  parameter int unsigned data_width = 256
);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] in_data;
  logic                  out0_valid;
  logic                  out0_ready;
  logic [data_width-1:0] out0_data;
  logic                  out1_valid;
  logic                  out1_ready;
  logic [data_width-1:0] out1_data;

  // Router side: accepts the upstream stream and drives both sinks.
  modport master (
    input  in_valid, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  // Environment side: produces the stream and consumes the sinks.
  modport slave (
    output in_valid, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux_route_ctrl.sv
// Routes a job of num_blk blocks of blk_len words, alternating whole blocks
// between sink 0 and sink 1 through a one-entry output buffer.
module demux_route_ctrl #(
  parameter int unsigned data_width = 256,
  parameter int unsigned blk_len    = 8,
  parameter int unsigned cnt_width  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [cnt_width-1:0] num_blk,
  output logic                 busy,
  output logic                 done,
  output logic                 demux_two,
  demux_route_if.master        bus
);

  localparam int unsigned wc_width = (blk_len > 1) ? $clog2(blk_len) : 1;
  localparam logic [wc_width-1:0] wc_last = wc_width'(blk_len - 1);

  typedef enum logic [1:0] {IDLE, ROUTE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [wc_width-1:0]   wcnt, wcnt_nxt;
  logic [cnt_width-1:0]  bcnt, bcnt_nxt;
  logic [cnt_width-1:0]  nblk, nblk_nxt;
  logic                  sel_nxt, busy_nxt, done_nxt;
  logic                  buf_valid, buf_valid_nxt;
  logic                  buf_sel, buf_sel_nxt;
  logic [data_width-1:0] buf_data, buf_data_nxt;
  logic                  sel_ready, in_xfer, out_xfer, last_word;

  // Buffer may refill in the same cycle its current word leaves.
  assign sel_ready    = buf_sel ? bus.out1_ready : bus.out0_ready;
  assign out_xfer     = buf_valid && sel_ready;
  assign bus.in_ready = (state == ROUTE) && (!buf_valid || sel_ready);
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign last_word    = (wcnt == wc_last) && (bcnt == (nblk - cnt_width'(1)));

  assign bus.out0_valid = buf_valid && !buf_sel;
  assign bus.out1_valid = buf_valid && buf_sel;
  assign bus.out0_data  = buf_sel ? '0 : buf_data;
  assign bus.out1_data  = buf_sel ? buf_data : '0;

  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    bcnt_nxt      = bcnt;
    nblk_nxt      = nblk;
    sel_nxt       = demux_two;
    done_nxt      = 1'b0;
    buf_valid_nxt = buf_valid;
    buf_sel_nxt   = buf_sel;
    buf_data_nxt  = buf_data;

    if (in_xfer) begin
      buf_data_nxt  = bus.in_data;
      buf_sel_nxt   = demux_two;
      buf_valid_nxt = 1'b1;
    end else if (out_xfer) begin
      buf_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (num_blk != '0) begin
            state_nxt = ROUTE;
            wcnt_nxt  = '0;
            bcnt_nxt  = '0;
            sel_nxt   = 1'b0;
            nblk_nxt  = num_blk;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ROUTE: begin
        // Select flips after the word that closes a block has been captured.
        if (in_xfer) begin
          if (wcnt == wc_last) begin
            wcnt_nxt = '0;
            bcnt_nxt = bcnt + cnt_width'(1);
            sel_nxt  = !demux_two;
          end else begin
            wcnt_nxt = wcnt + wc_width'(1);
          end
          if (last_word) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!buf_valid || out_xfer) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      bcnt      <= '0;
      nblk      <= '0;
      demux_two <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      buf_valid <= 1'b0;
      buf_sel   <= 1'b0;
      buf_data  <= '0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      bcnt      <= bcnt_nxt;
      nblk      <= nblk_nxt;
      demux_two <= sel_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      buf_valid <= buf_valid_nxt;
      buf_sel   <= buf_sel_nxt;
      buf_data  <= buf_data_nxt;
    end
  end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Bench for demux_route_ctrl: job vector table, reset-mid-job sequence and
// random backpressure jobs, checked against a block-alternation scoreboard.
module tb_demux_route_ctrl;
  localparam int DW  = 32;
  localparam int BLK = 2;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_blk;
  logic          busy, done, demux_two;

  demux_route_if #(.data_width(DW)) bus ();

  demux_route_ctrl #(.data_width(DW), .blk_len(BLK), .cnt_width(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_blk   (num_blk),
    .busy      (busy),
    .done      (done),
    .demux_two (demux_two),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sink;
  } exp_t;

  typedef struct {
    int nb; int pv; int pr0; int pr1; int mid; int stall; int exp0; int exp1;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced at each pre-edge sample.
  bit m_busy, m_done, m_sel;
  int m_wcnt, sent, rcvd, total, job_n0, job_n1;
  bit h0, h1, vld_hold;
  logic [DW-1:0] d0, d1;

  bit start_req;
  int nb_req, mid_nb, stall_req, stall1;
  int pv_g, pr0_g, pr1_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic pop_check(input bit k, input logic [DW-1:0] data);
    exp_t e;
    rcvd++;
    if (k) job_n1++; else job_n0++;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty actual=sink%0d required=no_output t=%0t", k, $time);
    end else begin
      e = sb.pop_front();
      chk("out_data", 64'(data), 64'(e.data));
      chk("out_sink", 64'(k), 64'(e.sink));
    end
  endtask

  task automatic sample();
    bit ix, o0x, o1x, was_busy;
    exp_t e;
    ix  = bus.in_valid && bus.in_ready;
    o0x = bus.out0_valid && bus.out0_ready;
    o1x = bus.out1_valid && bus.out1_ready;
    was_busy = m_busy;

    chk("done", 64'(done), 64'(m_done));
    chk("busy", 64'(busy), 64'(m_busy));
    if (m_busy) chk("demux_two", 64'(demux_two), 64'(m_sel));
    if (h0) begin
      chk("out0_hold_valid", 64'(bus.out0_valid), 64'(1));
      chk("out0_hold_data", 64'(bus.out0_data), 64'(d0));
    end
    if (h1) begin
      chk("out1_hold_valid", 64'(bus.out1_valid), 64'(1));
      chk("out1_hold_data", 64'(bus.out1_data), 64'(d1));
    end
    if (bus.out1_valid) chk("out0_zero", 64'(bus.out0_data), 64'(0));
    if (bus.out0_valid) chk("out1_zero", 64'(bus.out1_data), 64'(0));
    if ((bus.out0_valid && !bus.out0_ready) || (bus.out1_valid && !bus.out1_ready))
      chk("in_ready_gate", 64'(bus.in_ready), 64'(0));
    if (!m_busy)
      chk("idle_quiet", 64'({bus.in_ready, bus.out0_valid, bus.out1_valid}), 64'(0));

    if (o0x) pop_check(1'b0, bus.out0_data);
    if (o1x) pop_check(1'b1, bus.out1_data);

    if (ix) begin
      if (!m_busy || sent >= total) begin
        checks++;
        errors++;
        $display("FAIL extra_in actual=accepted required=refused t=%0t", $time);
      end else begin
        e.data = bus.in_data;
        e.sink = m_sel;
        sb.push_back(e);
        sent++;
        m_wcnt++;
        if (m_wcnt == BLK) begin
          m_wcnt = 0;
          m_sel  = !m_sel;
        end
      end
    end

    m_done = 1'b0;
    if (m_busy && (o0x || o1x) && rcvd == total) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end
    if (start && !was_busy) begin
      if (num_blk != 0) begin
        m_busy = 1'b1;
        m_sel  = 1'b0;
        m_wcnt = 0;
        sent   = 0;
        rcvd   = 0;
        total  = int'(num_blk) * BLK;
      end else begin
        m_done = 1'b1;
      end
    end

    if (stall_req != 0 && bus.out1_valid) begin
      stall1    = 5;
      stall_req = 0;
    end
    h0 = bus.out0_valid && !bus.out0_ready;
    h1 = bus.out1_valid && !bus.out1_ready;
    d0 = bus.out0_data;
    d1 = bus.out1_data;
    vld_hold = bus.in_valid && !bus.in_ready;
  endtask

  // Drive on the falling edge, sample just before the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (mid_nb != 0 && m_busy && sent >= 1) begin
      start_req = 1'b1;
      nb_req    = mid_nb;
      mid_nb    = 0;
    end
    start     = start_req;
    num_blk   = CW'(nb_req);
    start_req = 1'b0;
    bus.out0_ready = (int'($urandom_range(99)) < pr0_g);
    if (stall1 > 0) begin
      bus.out1_ready = 1'b0;
      stall1--;
    end else begin
      bus.out1_ready = (int'($urandom_range(99)) < pr1_g);
    end
    if (!vld_hold) begin
      bus.in_valid = (int'($urandom_range(99)) < pv_g);
      bus.in_data  = DW'($urandom);
    end
    #4;
    sample();
    @(posedge clk);
  endtask

  task automatic run_job(input vec_t v);
    int cyc;
    pv_g = v.pv; pr0_g = v.pr0; pr1_g = v.pr1;
    job_n0 = 0; job_n1 = 0;
    nb_req = v.nb; start_req = 1'b1;
    mid_nb = v.mid; stall_req = v.stall;
    cycle();
    cyc = 0;
    while ((m_busy || m_done) && cyc < 2000) begin
      cycle();
      cyc++;
    end
    if (m_busy || m_done) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=busy required=done nb=%0d t=%0t", v.nb, $time);
      finish_now();
    end
    chk("sink0_words", 64'(job_n0), 64'(v.exp0));
    chk("sink1_words", 64'(job_n1), 64'(v.exp1));
    mid_nb = 0;
    stall_req = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    chk({tag, "_out0_valid"}, 64'(bus.out0_valid), 64'(0));
    chk({tag, "_out1_valid"}, 64'(bus.out1_valid), 64'(0));
    chk({tag, "_demux_two"}, 64'(demux_two), 64'(0));
    chk({tag, "_out0_data"}, 64'(bus.out0_data), 64'(0));
    chk({tag, "_out1_data"}, 64'(bus.out1_data), 64'(0));
  endtask

  initial begin
    vec_t v;
    int nb;
    rst = 1'b1; start = 1'b0; num_blk = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    m_busy = 0; m_done = 0; m_sel = 0; m_wcnt = 0;
    sent = 0; rcvd = 0; total = 0; job_n0 = 0; job_n1 = 0;
    h0 = 0; h1 = 0; vld_hold = 0; d0 = '0; d1 = '0;
    start_req = 0; nb_req = 0; mid_nb = 0; stall_req = 0; stall1 = 0;
    pv_g = 0; pr0_g = 0; pr1_g = 0;

    //            nb  pv  pr0 pr1 mid stall exp0 exp1
    vecs[0] = '{3, 100, 100, 100, 0, 0, 4, 2};
    vecs[1] = '{3, 100, 100, 100, 0, 1, 4, 2};
    vecs[2] = '{0, 100, 100, 100, 0, 0, 0, 0};
    vecs[3] = '{2, 100, 100, 100, 5, 0, 2, 2};
    vecs[4] = '{1,  60,  50,  50, 0, 0, 2, 0};
    vecs[5] = '{5,  70,  40,  80, 0, 0, 6, 4};
    vecs[6] = '{4, 100, 100,  20, 0, 1, 4, 4};

    repeat (2) @(negedge clk);
    reset_checks("rst");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Reset while a word sits stalled in the buffer, then a clean job.
    pv_g = 100; pr0_g = 0; pr1_g = 100;
    nb_req = 4; start_req = 1'b1;
    repeat (4) cycle();
    @(negedge clk);
    chk("pre_rst_buffered", 64'(bus.out0_valid), 64'(1));
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    sb.delete();
    m_busy = 0; m_done = 0; h0 = 0; h1 = 0;
    @(negedge clk);
    rst = 1'b0;
    v = '{2, 100, 100, 100, 0, 0, 2, 2};
    run_job(v);

    for (int j = 0; j < 1000; j++) begin
      nb = int'($urandom_range(5));
      v = '{nb, 30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)),
            30 + int'($urandom_range(70)), 0, 0, ((nb + 1) / 2) * BLK, (nb / 2) * BLK};
      run_job(v);
    end

    chk("sb_drained", 64'(sb.size()), 64'(0));
    finish_now();
  end
endmodule
